// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared types and frame constants for the PS/2 receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int c_FRAME_BITS = 11;
    localparam int c_DATA_BITS  = c_FRAME_BITS - 3;  // minus start, parity, stop

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_fifo
// Purpose  : First-word-fall-through FIFO; head reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_fifo #(
    parameter int LOG2_DEPTH = 3,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_DEPTH = 2 ** LOG2_DEPTH;

    logic [WIDTH-1:0]    r_mem [c_DEPTH];
    logic [LOG2_DEPTH:0] r_wr_ptr;
    logic [LOG2_DEPTH:0] r_rd_ptr;
    logic                w_do_pop;
    logic                w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[LOG2_DEPTH] != r_rd_ptr[LOG2_DEPTH]) &&
                   (r_wr_ptr[LOG2_DEPTH-1:0] == r_rd_ptr[LOG2_DEPTH-1:0]);

    // A pop frees the slot being written, so push is allowed when full.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = empty ? '0 : r_mem[r_rd_ptr[LOG2_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[LOG2_DEPTH-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 device-to-host receiver: pin sync, clock deglitch,
//            11-bit frame deframing, timeout and scancode FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER     = 8,
    parameter int TIMEOUT    = 50000,
    parameter int LOG2_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [7:0] code,
    output logic       avail,
    output logic       err,
    output logic       ovr
);

    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic              r_filt;
    logic [7:0]        r_flt_cnt;
    logic              r_fall;
    ps2_state_t        r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par;
    logic [c_TO_W-1:0] r_to;
    logic              r_err, r_ovr;

    logic              w_good, w_push, w_pop, w_full, w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_filt    <= 1'b1;
            r_flt_cnt <= '0;
            r_fall    <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == 8'(FILTER - 1)) begin
                r_filt    <= r_clk_s2;
                r_flt_cnt <= '0;
                r_fall    <= r_filt;   // strobe only on a 1->0 flip
            end else begin
                r_flt_cnt <= r_flt_cnt + 8'd1;
            end
        end
    end

    // Odd parity: byte bits plus parity bit must carry an odd number of ones.
    assign w_good = r_dat_s2 && ((^r_shift) ^ r_par);
    assign w_push = r_fall && (r_state == STOP) && w_good;
    assign w_pop  = rd && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_to      <= '0;
            r_err     <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            r_ovr <= 1'b0;
            if (r_state == IDLE || r_fall) r_to <= '0;
            else                           r_to <= r_to + 1'b1;

            if (r_fall) begin
                case (r_state)
                    IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'(c_DATA_BITS - 1)) r_state <= PARITY;
                    end
                    PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (!w_good)                r_err <= 1'b1;
                        else if (w_full && !w_pop)  r_ovr <= 1'b1;
                    end
                endcase
            end else if (r_state != IDLE && r_to == c_TO_W'(TIMEOUT - 1)) begin
                r_state <= IDLE;
                r_err   <= 1'b1;
                r_to    <= '0;
            end
        end
    end

    ps2_fifo #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (r_shift),
        .pop   (w_pop),
        .dout  (code),
        .full  (w_full),
        .empty (w_empty)
    );

    assign avail = !w_empty;
    assign err   = r_err;
    assign ovr   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx
// Purpose  : Self-checking bench for ps2_rx with a frame-level queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

    localparam int FILTER     = 4;
    localparam int TIMEOUT    = 200;
    localparam int LOG2_DEPTH = 3;
    localparam int DEPTH      = 2 ** LOG2_DEPTH;
    localparam int SETUP      = 10;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst, ps2_clk, ps2_data, rd;
    logic [7:0] code;
    logic       avail, err, ovr;

    ps2_rx #(
        .FILTER     (FILTER),
        .TIMEOUT    (TIMEOUT),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd       (rd),
        .code     (code),
        .avail    (avail),
        .err      (err),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int err_seen = 0, ovr_seen = 0, err_long = 0, ovr_long = 0, both_seen = 0;
    logic err_q = 1'b0, ovr_q = 1'b0;
    logic [7:0] q[$];

    always @(negedge clk) begin
        if (err) err_seen++;
        if (ovr) ovr_seen++;
        if (err && err_q) err_long++;
        if (ovr && ovr_q) ovr_long++;
        if (err && ovr)   both_seen++;
        err_q = err;
        ovr_q = ovr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drop_clk(input bit d);
        @(posedge clk); #1 ps2_data = d;
        repeat (SETUP) @(posedge clk);
        #1 ps2_clk = 1'b0;
    endtask

    task automatic drive_bit(input bit d);
        drop_clk(d);
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic p;
        p = par_ok ? ~(^b) : (^b);
        return {stop_ok, p, b, 1'b0};   // bit 0 is sent first
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic [10:0] f;
        int e0, o0, exp_e, exp_o;
        f = make_frame(b, par_ok, stop_ok);
        e0 = err_seen; o0 = ovr_seen; exp_e = 0; exp_o = 0;
        for (int i = 0; i < 11; i++) drive_bit(f[i]);
        if (!(par_ok && stop_ok)) exp_e = 1;
        else if (q.size() < DEPTH) q.push_back(b);
        else exp_o = 1;
        @(negedge clk);
        check("frame_err", err_seen - e0, exp_e);
        check("frame_ovr", ovr_seen - o0, exp_o);
        check("frame_avail", avail, q.size() != 0);
        check("frame_code", code, (q.size() != 0) ? q[0] : 8'h00);
    endtask

    task automatic pop_one();
        logic [7:0] exp_h;
        exp_h = (q.size() != 0) ? q[0] : 8'h00;
        @(negedge clk);
        check("pop_head", code, exp_h);
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        check("pop_avail", avail, q.size() != 0);
        check("pop_code", code, (q.size() != 0) ? q[0] : 8'h00);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         par_ok;
        bit         stop_ok;
        int         pre_pops;
        bit         exp_err;
        bit         exp_ovr;
        bit         exp_avail;
        logic [7:0] exp_code;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] f;
        int e0, o0;

        tbl[0] = '{8'h1C, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h1C};
        tbl[1] = '{8'h1C, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{8'hF0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'hF0};
        tbl[3] = '{8'h5A, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 8'h00};
        for (int i = 4; i < 13; i++)
            tbl[i] = '{8'(i - 3), 1'b1, 1'b1, 0, 1'b0, (i == 12), 1'b1, 8'h01};

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_code", code, 8'h00);
        check("reset_avail", avail, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_ovr", ovr, 1'b0);

        for (int i = 0; i < 13; i++) begin
            repeat (tbl[i].pre_pops) pop_one();
            e0 = err_seen; o0 = ovr_seen;
            send_frame(tbl[i].data, tbl[i].par_ok, tbl[i].stop_ok);
            check("tbl_err", err_seen - e0, tbl[i].exp_err);
            check("tbl_ovr", ovr_seen - o0, tbl[i].exp_ovr);
            check("tbl_avail", avail, tbl[i].exp_avail);
            check("tbl_code", code, tbl[i].exp_code);
        end
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", code, i);
            pop_one();
        end
        check("ovf_drained", avail, 1'b0);

        // Stop-edge push latency: avail rises exactly FILTER+3 edges after the pin drop.
        f = make_frame(8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        drop_clk(1'b1);
        repeat (FILTER + 2) @(posedge clk);
        @(negedge clk);
        check("lat_avail_before", avail, 1'b0);
        @(posedge clk); @(negedge clk);
        check("lat_avail_after", avail, 1'b1);
        check("lat_code", code, 8'h3C);
        repeat (HALF - FILTER - 4) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        q.push_back(8'h3C);
        pop_one();

        // Short low glitch with data low must not start a frame.
        e0 = err_seen;
        @(posedge clk); #1 ps2_data = 1'b0; ps2_clk = 1'b0;
        repeat (FILTER - 1) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (TIMEOUT + 50) @(posedge clk);
        #1 ps2_data = 1'b1;
        @(negedge clk);
        check("glitch_err", err_seen - e0, 0);
        check("glitch_avail", avail, 1'b0);

        // Abandoned frame: err exactly TIMEOUT cycles after the last fall.
        f = make_frame(8'hA5, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive_bit(f[i]);
        e0 = err_seen;
        drop_clk(f[4]);
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (FILTER + 2 + TIMEOUT - HALF) @(posedge clk);
        @(negedge clk);
        check("to_err_early", err, 1'b0);
        @(posedge clk); @(negedge clk);
        check("to_err_pulse", err, 1'b1);
        @(posedge clk); @(negedge clk);
        check("to_err_clear", err, 1'b0);
        check("to_err_count", err_seen - e0, 1);
        check("to_avail", avail, 1'b0);
        send_frame(8'h76, 1'b1, 1'b1);

        // Reset after parity bit with two bytes stored.
        send_frame(8'h11, 1'b1, 1'b1);
        check("rst_pre_level", q.size(), 2);
        f = make_frame(8'h22, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("rst_code", code, 8'h00);
        check("rst_avail", avail, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        e0 = err_seen; o0 = ovr_seen;
        drive_bit(f[10]);
        @(negedge clk);
        check("rst_stop_avail", avail, 1'b0);
        check("rst_stop_err", err_seen - e0, 0);
        check("rst_stop_ovr", ovr_seen - o0, 0);
        pop_one();

        for (int n = 0; n < 24; n++) begin
            int pops;
            pops = $urandom_range(0, 2);
            repeat (pops) pop_one();
            send_frame(8'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        end
        while (q.size() != 0) pop_one();

        check("err_width", err_long, 0);
        check("ovr_width", ovr_long, 0);
        check("err_ovr_exclusive", both_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
